// File: rtl/xor4_parity_sched_v.sv
// Round-robin two-requester parity engine sharing one 4-input XOR stage, one nibble per cycle.
// Define XOR4_PARITY_SCHED_ODD_EN for odd parity output; default build produces even parity.
module xor4_parity_sched_v #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_a_valid,
  input  logic [4*NIBBLES-1:0] i_a_data,
  output logic                 o_a_ready,
  input  logic                 i_b_valid,
  input  logic [4*NIBBLES-1:0] i_b_data,
  output logic                 o_b_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity,
  output logic                 o_id,
  output logic                 o_busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

`ifdef XOR4_PARITY_SCHED_ODD_EN
  localparam logic PARITY_INV = 1'b1;
`else
  localparam logic PARITY_INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          ptr_q, ptr_d;     // 0: A wins a tie, 1: B wins a tie
  logic          valid_q, valid_d;
  logic          parity_q, parity_d;
  logic          id_q, id_d;

  logic          grant_a, grant_b;
  logic [3:0]    nib_arr [NIBBLES];
  logic [3:0]    nib_sel;
  logic          xor4_out;
  logic          acc_nxt;

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign nib_arr[gi] = word_q[4*gi +: 4];
  end

  // The single shared reduction stage: only the sequenced nibble reaches it.
  assign nib_sel  = nib_arr[cnt_q];
  assign xor4_out = ^nib_sel;
  assign acc_nxt  = acc_q ^ xor4_out;

  // Reset is folded into the grant so no requester sees ready while held in reset.
  assign grant_a = i_rst_n && (state_q == IDLE) && i_a_valid && (!i_b_valid || !ptr_q);
  assign grant_b = i_rst_n && (state_q == IDLE) && i_b_valid && (!i_a_valid ||  ptr_q);

  assign o_a_ready = grant_a;
  assign o_b_ready = grant_b;
  assign o_valid   = valid_q;
  assign o_parity  = parity_q;
  assign o_id      = id_q;
  assign o_busy    = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    parity_d = parity_q;
    id_d     = id_q;
    case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          word_d  = grant_a ? i_a_data : i_b_data;
          id_d    = grant_b;
          ptr_d   = grant_a;
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_NIB) begin
          cnt_d    = '0;
          parity_d = acc_nxt ^ PARITY_INV;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      ptr_q    <= 1'b0;
      valid_q  <= 1'b0;
      parity_q <= 1'b0;
      id_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      parity_q <= parity_d;
      id_q     <= id_d;
    end
  end

endmodule
